// File: rtl/hazard_sequencer.sv
// Control-only hazard sequencer for the 5-stage core: stage enables/flushes, ID-stage forward
// selects, stall classification, halt drain and a saturating stall-cycle counter.

package hazard_sequencer_pkg;
   typedef enum logic [2:0] {
      NO_STALL   = 3'd0,
      IFID_STALL = 3'd1,
      IDEX_STALL = 3'd2,
      FULL_STALL = 3'd3
   } pipe_stall_t;
endpackage

module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter bit FWD_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       idex_wsel,
   input  logic             idex_RegWr,
   input  logic             idex_DataRead,
   input  logic [4:0]       exmem_wsel,
   input  logic             exmem_RegWr,
   input  logic             exmem_dreq,
   input  logic             exmem_Halt,
   input  logic [4:0]       memwb_wsel,
   input  logic             memwb_RegWr,
   input  logic             ex_redirect,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             fwd_exmem_a,
   output logic             fwd_memwb_a,
   output logic             fwd_exmem_b,
   output logic             fwd_memwb_b,
   output logic [2:0]       stall,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } seq_state_t;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   pipe_stall_t       stall_s;
   logic              idex_hit_rs_s, idex_hit_rt_s, exmem_hit_rs_s, exmem_hit_rt_s;
   logic              load_use_s, dmem_wait_s;
   logic              unused_s;

   // The register file writes before it reads, so MEM|WB producers never need forwarding here.
   assign unused_s = ^{memwb_wsel, memwb_RegWr};

   assign idex_hit_rs_s  = idex_RegWr  & (idex_wsel  != 5'd0) & (idex_wsel  == id_rs);
   assign idex_hit_rt_s  = idex_RegWr  & (idex_wsel  != 5'd0) & (idex_wsel  == id_rt);
   assign exmem_hit_rs_s = exmem_RegWr & (exmem_wsel != 5'd0) & (exmem_wsel == id_rs);
   assign exmem_hit_rt_s = exmem_RegWr & (exmem_wsel != 5'd0) & (exmem_wsel == id_rt);
   assign dmem_wait_s    = exmem_dreq & ~dhit;

   // Without forwarding every in-flight RAW producer must retire before the consumer may read.
   assign load_use_s = FWD_EN ? (idex_DataRead & (idex_hit_rs_s | idex_hit_rt_s))
                              : (idex_hit_rs_s | idex_hit_rt_s | exmem_hit_rs_s | exmem_hit_rt_s);

   assign stall     = stall_s;
   assign halt      = (state_q == HALTED);
   assign stall_cnt = stall_cnt_q;

   // Forward selects: the youngest producer (ID|EX) shadows an older EX|MEM match.
   always_comb begin
      fwd_exmem_a = 1'b0;
      fwd_memwb_a = 1'b0;
      fwd_exmem_b = 1'b0;
      fwd_memwb_b = 1'b0;
      if (FWD_EN && !RST && state_q == RUN) begin
         fwd_exmem_a = idex_hit_rs_s;
         fwd_memwb_a = ~idex_hit_rs_s & exmem_hit_rs_s;
         fwd_exmem_b = idex_hit_rt_s;
         fwd_memwb_b = ~idex_hit_rt_s & exmem_hit_rt_s;
      end else begin
         fwd_exmem_a = 1'b0;
      end
   end

   // Per-cycle enables, flushes, stall class and next state.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_s     = NO_STALL;
      state_d     = state_q;
      if (RST) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (dmem_wait_s) begin
                  stall_s = FULL_STALL;
               end else if (exmem_Halt) begin
                  exmem_en    = 1'b1;
                  memwb_en    = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  state_d     = DRAIN;
               end else if (ex_redirect) begin
                  // Fetch restarts at the target even if the old fetch is still outstanding.
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use_s) begin
                  stall_s = IDEX_STALL;
                  {idex_en, exmem_en, memwb_en} = 3'b111;
                  idex_flush = 1'b1;
               end else if (!ihit) begin
                  stall_s = IFID_STALL;
                  {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                  ifid_flush = 1'b1;
               end else begin
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
               end
            end
            DRAIN: begin
               memwb_en = 1'b1;
               state_d  = HALTED;
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Saturating count of stalled RUN cycles; halting does not clear it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == RUN && stall_s != NO_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Sequencer state and counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= RUN;
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
